// File: rtl/spm_dma_pkg.sv
// Shared constants, signal levels and FSM encoding
// for the SPM block-copy DMA engine.
package spm_dma_pkg;

  localparam int SPM_ADDR_W = 12;
  localparam int BUS_ADDR_W = 30;
  localparam int DATA_W     = 32;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_FIN
  } state_e;

endpackage

// File: rtl/spm_dma_port_arb.sv
// SPM port-B mux: the MEM stage always wins,
// DMA writes only take idle port cycles.
module spm_dma_port_arb
  import spm_dma_pkg::*;
(
  input  logic                  mem_spm_as_,
  input  logic                  mem_spm_rw,
  input  logic [SPM_ADDR_W-1:0] mem_spm_addr,
  input  logic [DATA_W-1:0]     mem_spm_wr_data,
  output logic [DATA_W-1:0]     mem_spm_rd_data,
  input  logic                  dma_wr_req,
  input  logic [SPM_ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wr_data,
  output logic                  dma_wr_ack,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data
);

  assign mem_spm_rd_data = spm_rd_data;

  // Fixed priority select: MEM, then DMA, else idle
  always_comb begin
    spm_addr    = mem_spm_addr;
    spm_as_     = DISABLE_;
    spm_rw      = READ;
    spm_wr_data = mem_spm_wr_data;
    dma_wr_ack  = 1'b0;
    if (mem_spm_as_ == ENABLE_) begin
      spm_as_ = ENABLE_;
      spm_rw  = mem_spm_rw;
    end else if (dma_wr_req) begin
      spm_addr    = dma_addr;
      spm_as_     = ENABLE_;
      spm_rw      = WRITE;
      spm_wr_data = dma_wr_data;
      dma_wr_ack  = 1'b1;
    end
  end

endmodule

// File: rtl/spm_dma.sv
// Single-channel bus-to-SPM copy engine; owns
// SPM port B and shares it with the MEM stage.
module spm_dma
  import spm_dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [BUS_ADDR_W-1:0] cfg_src,
  input  logic [SPM_ADDR_W-1:0] cfg_dst,
  input  logic [SPM_ADDR_W:0]   cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_,
  input  logic [SPM_ADDR_W-1:0] mem_spm_addr,
  input  logic                  mem_spm_as_,
  input  logic                  mem_spm_rw,
  input  logic [DATA_W-1:0]     mem_spm_wr_data,
  output logic [DATA_W-1:0]     mem_spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data
);

  localparam int LW = SPM_ADDR_W + 1;
  localparam int EW = SPM_ADDR_W + 2;

  state_e                state_q, state_d;
  logic [BUS_ADDR_W-1:0] src_q, src_d;
  logic [SPM_ADDR_W-1:0] dst_q, dst_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic [DATA_W-1:0]     buf_q, buf_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  dma_wr_req, dma_wr_ack;
  logic [EW-1:0]         end_w;
  logic                  rng_err, go, last;

  // End of region may reach exactly 2^SPM_ADDR_W
  assign end_w   = EW'(cfg_dst) + EW'(cfg_len);
  assign rng_err = end_w > EW'(1 << SPM_ADDR_W);
  assign go      = cfg_start && (cfg_len != '0)
                   && !rng_err;
  assign last    = (rem_q == LW'(1)) || abort_q
                   || cfg_abort;
  assign err     = err_q;
  assign bus_rw  = READ;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_REQ;
      ST_REQ: begin
        if (abort_q || cfg_abort)
          state_d = ST_FIN;
        else if (bus_grnt_ == ENABLE_)
          state_d = ST_RD;
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: if (bus_rdy_ == ENABLE_) state_d = ST_WR;
      ST_WR: begin
        if (dma_wr_ack)
          state_d = last ? ST_FIN : ST_RD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy       = 1'b0;
    done       = done_q;
    bus_req_   = DISABLE_;
    bus_as_    = DISABLE_;
    bus_addr   = '0;
    dma_wr_req = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        busy     = 1'b1;
        bus_req_ = ENABLE_;
      end
      ST_RD: begin
        busy     = 1'b1;
        bus_req_ = ENABLE_;
        bus_as_  = ENABLE_;
        bus_addr = src_q;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        bus_req_ = ENABLE_;
      end
      ST_WR: begin
        busy       = 1'b1;
        bus_req_   = ENABLE_;
        dma_wr_req = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Transfer registers: addresses, count, buffer, flags
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    abort_d = abort_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cfg_start) begin
          err_d = rng_err;
          if (cfg_len == '0 || rng_err) begin
            done_d = 1'b1;
          end else begin
            src_d = cfg_src;
            dst_d = cfg_dst;
            rem_d = cfg_len;
          end
        end
      end
      ST_FIN:  abort_d = 1'b0;
      default: begin
        if (cfg_abort) abort_d = 1'b1;
        if (state_q == ST_WAIT &&
            bus_rdy_ == ENABLE_)
          buf_d = bus_rd_data;
        if (state_q == ST_WR && dma_wr_ack) begin
          src_d = src_q + BUS_ADDR_W'(1);
          dst_d = dst_q + SPM_ADDR_W'(1);
          rem_d = rem_q - LW'(1);
        end
      end
    endcase
  end

  // Datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  spm_dma_port_arb u_arb (
    .mem_spm_as_     (mem_spm_as_),
    .mem_spm_rw      (mem_spm_rw),
    .mem_spm_addr    (mem_spm_addr),
    .mem_spm_wr_data (mem_spm_wr_data),
    .mem_spm_rd_data (mem_spm_rd_data),
    .dma_wr_req      (dma_wr_req),
    .dma_addr        (dst_q),
    .dma_wr_data     (buf_q),
    .dma_wr_ack      (dma_wr_ack),
    .spm_addr        (spm_addr),
    .spm_as_         (spm_as_),
    .spm_rw          (spm_rw),
    .spm_wr_data     (spm_wr_data),
    .spm_rd_data     (spm_rd_data)
  );

endmodule

// File: tb/tb_spm_dma.sv
// Directed bench for spm_dma: vector table of
// transfers plus contention/abort/reset sequences.
module tb_spm_dma;
  import spm_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [29:0] cfg_src = '0;
  logic [11:0] cfg_dst = '0;
  logic [12:0] cfg_len = '0;
  logic        busy, done, err;
  logic        bus_req_, bus_as_, bus_rw;
  logic        bus_grnt_ = 1'b1;
  logic        bus_rdy_ = 1'b1;
  logic [29:0] bus_addr;
  logic [31:0] bus_rd_data = '0;
  logic [11:0] mem_spm_addr = '0;
  logic        mem_spm_as_ = 1'b1;
  logic        mem_spm_rw = 1'b1;
  logic [31:0] mem_spm_wr_data = '0;
  logic [31:0] mem_spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data, spm_rd_data;

  logic [31:0] spm_mem [4096];
  assign spm_rd_data = spm_mem[spm_addr];

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int gdelay = 0;
  int gcnt = 0;
  int dma_wr_cnt, done_cnt, rd_cnt, as_viol;
  int first_wr_cyc;
  int rd_bad = 0;
  bit rd_pend = 0;
  logic [29:0] pend_addr = '0;

  spm_dma dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
    .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_),
    .mem_spm_addr(mem_spm_addr),
    .mem_spm_as_(mem_spm_as_),
    .mem_spm_rw(mem_spm_rw),
    .mem_spm_wr_data(mem_spm_wr_data),
    .mem_spm_rd_data(mem_spm_rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bw(
    input logic [29:0] a);
    return {a[15:0], 16'h0} ^ {2'b0, a}
           ^ 32'hC3A5_0F1E;
  endfunction

  // Bus slave: grant after gdelay, rdy_ one cycle after as_
  always @(negedge clk) begin
    bus_rdy_ = 1'b1;
    if (rd_pend) begin
      bus_rdy_    = 1'b0;
      bus_rd_data = bw(pend_addr);
      rd_pend     = 0;
    end
    if (!bus_as_) begin
      rd_pend   = 1;
      pend_addr = bus_addr;
    end
    if (!bus_req_) begin
      if (gcnt >= gdelay) bus_grnt_ = 1'b0;
      gcnt++;
    end else begin
      bus_grnt_ = 1'b1;
      gcnt      = 0;
    end
  end

  // SPM model and event counters
  always @(posedge clk) begin
    if (!spm_as_ && spm_rw == WRITE)
      spm_mem[spm_addr] = spm_wr_data;
    if (!spm_as_ && mem_spm_as_) begin
      dma_wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (done) done_cnt++;
    if (!bus_as_) rd_cnt++;
    if (!bus_as_ && bus_grnt_) as_viol++;
    if (mem_spm_rd_data !== spm_rd_data) rd_bad++;
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic clr();
    dma_wr_cnt   = 0;
    done_cnt     = 0;
    rd_cnt       = 0;
    as_viol      = 0;
    first_wr_cyc = -1;
  endtask

  task automatic start(input logic [29:0] s,
                       input logic [11:0] d,
                       input logic [12:0] l,
                       input logic ab);
    @(posedge clk); #1;
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = l;
    cfg_start = 1'b1;
    cfg_abort = ab;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic wait_done(output bit ok,
                           output logic b,
                           output logic r);
    ok = 0;
    b  = 1'bx;
    r  = 1'bx;
    for (int i = 0; i < 800; i++) begin
      if (done) begin
        ok = 1;
        b  = busy;
        r  = bus_req_;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  function automatic int bad_words(
    input logic [29:0] s, input logic [11:0] d,
    input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [11:0] da;
      logic [29:0] sa;
      da = d + 12'(i);
      sa = s + 30'(i);
      if (spm_mem[da] !== bw(sa)) bad++;
    end
    return bad;
  endfunction

  typedef struct {
    logic [29:0] src;
    logic [11:0] dst;
    logic [12:0] len;
    int          gd;
    logic        err;
    int          words;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v,
                         input string nm);
    bit ok;
    logic b, r;
    clr();
    gdelay = v.gd;
    start(v.src, v.dst, v.len, 1'b0);
    wait_done(ok, b, r);
    chk({nm, " done_seen"}, 64'(ok), 64'd1);
    chk({nm, " busy_at_done"}, 64'(b), 64'd0);
    chk({nm, " req_at_done"}, 64'(r), 64'd1);
    chk({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, " err"}, 64'(err), 64'(v.err));
    chk({nm, " dma_writes"}, 64'(dma_wr_cnt),
        64'(v.words));
    chk({nm, " bus_reads"}, 64'(rd_cnt),
        64'(v.words));
    chk({nm, " as_before_grant"}, 64'(as_viol),
        64'd0);
    chk({nm, " bad_words"},
        64'(bad_words(v.src, v.dst, v.words)),
        64'd0);
  endtask

  initial begin
    bit ok;
    logic b, r;
    int n, rd_c;

    for (int i = 0; i < 4096; i++)
      spm_mem[i] = 32'hDEAD_0000 | 32'(i);

    vecs[0] = '{30'h100, 12'h010, 13'd4, 0, 1'b0, 4};
    vecs[1] = '{30'h3FFF_FFFE, 12'h200, 13'd4, 0,
                1'b0, 4};
    vecs[2] = '{30'h0, 12'hFFE, 13'd4, 0, 1'b1, 0};
    vecs[3] = '{30'h0, 12'h020, 13'd0, 0, 1'b0, 0};
    vecs[4] = '{30'h40, 12'h300, 13'd3, 10, 1'b0, 3};
    vecs[5] = '{30'h80, 12'hFFC, 13'd4, 0, 1'b0, 4};
    vecs[6] = '{30'h80, 12'hFFD, 13'd4, 0, 1'b1, 0};

    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",
        {busy, done, err, bus_req_, bus_as_, bus_rw,
         spm_as_, bus_addr},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, READ,
         1'b1, 30'h0});
    reset = 1'b0;

    for (int k = 0; k < 7; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // MEM holds port B for 5 cycles from WR entry
    clr();
    gdelay = 0;
    start(30'h500, 12'h080, 13'd2, 1'b0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus_as_) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("cont rd_seen", 64'(ok), 64'd1);
    rd_c = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      mem_spm_as_     = 1'b0;
      mem_spm_rw      = WRITE;
      mem_spm_addr    = 12'h700 + 12'(k);
      mem_spm_wr_data = 32'hC0DE_0000 | 32'(k);
      @(posedge clk); #1;
    end
    mem_spm_as_ = 1'b1;
    mem_spm_rw  = READ;
    wait_done(ok, b, r);
    chk("cont done_seen", 64'(ok), 64'd1);
    chk("cont defer", 64'(first_wr_cyc - rd_c),
        64'd7);
    chk("cont dma_writes", 64'(dma_wr_cnt), 64'd2);
    chk("cont bad_words",
        64'(bad_words(30'h500, 12'h080, 2)), 64'd0);
    n = 0;
    for (int k = 0; k < 5; k++)
      if (spm_mem[12'h700 + 12'(k)] !==
          (32'hC0DE_0000 | 32'(k))) n++;
    chk("cont mem_words", 64'(n), 64'd0);
    mem_spm_as_  = 1'b0;
    mem_spm_addr = 12'h702;
    #1;
    chk("cont mem_rd", 64'(mem_spm_rd_data),
        64'hC0DE_0002);
    mem_spm_as_ = 1'b1;

    // Abort in WAIT of the third word
    clr();
    start(30'h600, 12'h400, 13'd8, 1'b0);
    n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(posedge clk); #1;
      if (!bus_as_) n++;
    end
    @(posedge clk); #1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    wait_done(ok, b, r);
    chk("abort done_seen", 64'(ok), 64'd1);
    chk("abort dma_writes", 64'(dma_wr_cnt), 64'd3);
    chk("abort bus_reads", 64'(rd_cnt), 64'd3);
    chk("abort done_pulses", 64'(done_cnt), 64'd1);
    chk("abort req_at_done", 64'(r), 64'd1);
    chk("abort bad_words",
        64'(bad_words(30'h600, 12'h400, 3)), 64'd0);
    chk("abort untouched", 64'(spm_mem[12'h403]),
        64'hDEAD_0403);

    // Abort in REQ before grant
    clr();
    gdelay = 10;
    start(30'h700, 12'h600, 13'd4, 1'b0);
    @(posedge clk); #1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    wait_done(ok, b, r);
    chk("reqabort done_seen", 64'(ok), 64'd1);
    chk("reqabort bus_reads", 64'(rd_cnt), 64'd0);
    chk("reqabort dma_writes", 64'(dma_wr_cnt),
        64'd0);
    gdelay = 0;

    // Start with simultaneous abort: abort ignored
    clr();
    start(30'h800, 12'h640, 13'd2, 1'b1);
    wait_done(ok, b, r);
    chk("startabort dma_writes", 64'(dma_wr_cnt),
        64'd2);
    chk("startabort bad_words",
        64'(bad_words(30'h800, 12'h640, 2)), 64'd0);

    // Reset during WR, then a fresh transfer
    clr();
    start(30'h900, 12'h500, 13'd4, 1'b0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!spm_as_ && mem_spm_as_) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst wr_seen", 64'(ok), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_state",
        {busy, done, err, bus_req_, bus_as_, bus_rw,
         spm_as_, bus_addr},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, READ,
         1'b1, 30'h0});
    reset = 1'b0;
    run_vec(vecs[0], "after_rst");

    chk("mem_rd_passthru", 64'(rd_bad), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spm_dma.md
Name: spm_dma

Overview:
- Single-channel block-copy engine that fills the scratchpad from the external bus, e.g. a boot loader copying a program image into SPM.
- Acts as a bus master on the external bus.
- Owns SPM port B: arbitrates it between the MEM stage (fixed priority) and its own DMA writes.
- Sits between the MEM-stage SPM interface and the SPM dual-port RAM's port B. Port A (IF) is untouched.

Parameters:
- SPM_ADDR_W, 12, SPM word-address width (4096 words).
- BUS_ADDR_W, 30, external bus word-address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; starts a transfer, ignored while busy.
- cfg_abort  in  1  one-cycle pulse; stops the transfer after the current word.
- cfg_src  in  BUS_ADDR_W  bus source word address, sampled on start.
- cfg_dst  in  SPM_ADDR_W  SPM destination word address, sampled on start.
- cfg_len  in  SPM_ADDR_W+1  word count, sampled on start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion, abort or error.
- err  out  1  sticky range error; cleared by the next accepted start.
- bus_req_  out  1  bus request, active low.
- bus_grnt_  in  1  bus grant, active low.
- bus_addr  out  BUS_ADDR_W  bus address.
- bus_as_  out  1  address strobe, active low.
- bus_rw  out  1  read/write; always READ.
- bus_rd_data  in  DATA_W  bus read data.
- bus_rdy_  in  1  bus ready, active low.
- mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_wr_data  in  as SPM  MEM-stage request.
- mem_spm_rd_data  out  DATA_W  MEM-stage read data.
- spm_addr, spm_as_, spm_rw, spm_wr_data  out  as SPM  SPM port B request.
- spm_rd_data  in  DATA_W  SPM port B data.

Behaviour:
- Reset values:
  - busy=0, done=0, err=0.
  - bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0.
  - State IDLE, word buffer empty.
- Port B mux is combinational.
  - MEM request present (mem_spm_as_==ENABLE_): port B = MEM signals.
  - Otherwise the DMA write, if pending.
  - Otherwise spm_as_ = DISABLE_.
  - mem_spm_rd_data = spm_rd_data, always passed through.
  - The MEM stage is never stalled.
- Start acceptance (IDLE only):
  - cfg_len==0: done pulses next cycle, no bus activity.
  - cfg_dst+cfg_len > 2^SPM_ADDR_W: err=1, done pulses, no bus activity.
  - Otherwise latch src/dst/len (remaining=len), busy=1, go to REQ.
- FSM:
  - REQ: bus_req_=0. When bus_grnt_==0, go to RD.
  - RD: one cycle; bus_as_=0, bus_addr=src, bus_rw=READ. Go to WAIT.
  - WAIT: hold until bus_rdy_==0, then capture bus_rd_data into the buffer. Go to WR.
  - WR: request port B write (spm_addr=dst, spm_rw=WRITE, spm_wr_data=buffer). Stay in WR while the MEM stage holds the port. On the cycle the write is issued:
    - src+1, dst+1, remaining-1.
    - If remaining becomes 0 or an abort is pending, go to FIN; else go to RD.
  - FIN: bus_req_=1, busy=0, done=1 for one cycle. Go to IDLE.
- Bus ownership: bus_req_ stays low from REQ through the last WR (burst hold) and is released in FIN.
- Abort:
  - Sets a pending flag when it arrives in REQ, RD, WAIT or WR.
  - The in-flight bus read completes and its word is written to SPM. No further reads are issued.
  - Abort in REQ before grant goes straight to FIN.
  - Abort in IDLE is ignored.
- Address wrap: the bus address wraps modulo 2^BUS_ADDR_W. SPM never wraps because of the range check at start.
- Reset mid-transfer: all state returns to reset values. A partially copied region is left as is.
- Simultaneous start and abort in IDLE: the start is accepted and the abort is ignored.

Decomposition:
- Shared package / global config: SPM_ADDR_W, state encodings (IDLE, REQ, RD, WAIT, WR, FIN).
- Existing defines reused: ENABLE_, DISABLE_, READ, WRITE.
- Natural sub-module: spm_port_arb, the combinational port-B mux with MEM priority. It outputs dma_wr_ack to the FSM.

Test Plan:
- Basic copy: src=0x100, dst=0x010, len=4, grant immediate, rdy_ one cycle after as_ -> SPM words 0x010..0x013 equal bus words 0x100..0x103; done pulses once; busy falls the same cycle; bus_req_ released.
- MEM contention: MEM issues back-to-back writes for 5 cycles during a WR state -> DMA write deferred exactly 5 cycles; MEM data lands; final SPM contents are correct; mem_spm_rd_data never corrupted.
- Range error: dst=0xFFE, len=4 -> err=1, done pulse, bus_req_ never asserted, SPM unchanged.
- Abort: len=8, abort asserted in WAIT of word 3 -> exactly 3 words written, done pulse, bus released.
- Zero length and late grant: len=0 -> done only; separately, grant delayed 10 cycles -> no as_ before grant.
- Reset mid-transfer: reset during WR -> all outputs return to reset values next cycle; a new start then succeeds.
